// File: rtl/data_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single data bus controller.
// Each granted access runs IDLE -> CMD -> WAIT -> RESP; bad accesses go straight to RESP with err.
module data_bus_arbiter #(
  parameter int TIMEOUT  = 16,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        bus_wd,
  output logic        bus_rd,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  input  logic        bus_busy,
  output logic [1:0]  owner,
  output logic [1:0]  dbg_state
);

  // Requester side: mN_req is held until mN_ack; ack is a one-cycle pulse with err/rdata valid
  // in that cycle. Bus side: a strobe fires only in a CMD cycle where bus_ready=1 and bus_busy=0.
  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam int CW = $clog2(TIMEOUT + READ_LAT + 2);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic        last_q, last_d;       // 1 = m1 was granted last
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        go;
  logic        grant1;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_bad;

  assign go     = bus_ready && !bus_busy;
  // m1 wins when it is alone, or on a tie when m0 was granted last
  assign grant1 = m1_req && (!m0_req || !last_q);

  assign sel_we    = grant1 ? m1_we    : m0_we;
  assign sel_size  = grant1 ? m1_size  : m0_size;
  assign sel_addr  = grant1 ? m1_addr  : m0_addr;
  assign sel_wdata = grant1 ? m1_wdata : m0_wdata;
  assign sel_bad   = (sel_size == 2'b11) ||
                     (sel_size == 2'b01 && sel_addr[0]) ||
                     (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 2'b00;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = grant1 ? 2'b10 : 2'b01;
          last_d  = grant1;
          we_d    = sel_we;
          size_d  = sel_size;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          rdata_d = '0;
          err_d   = sel_bad;
          cnt_d   = '0;
          state_d = sel_bad ? RESP : CMD;
        end
      end
      CMD: begin
        if (go) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (we_q) begin
          state_d = RESP;
        end else if (cnt_q == CW'(READ_LAT)) begin
          rdata_d = bus_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        owner_d = 2'b00;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rdata_q is cleared at grant and only loaded for reads, so writes and errors return 0
  always_comb begin
    bus_rd   = 1'b0;
    bus_wd   = 1'b0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_err   = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    case (state_q)
      CMD: begin
        bus_rd = go && !we_q;
        bus_wd = go && we_q;
      end
      RESP: begin
        if (owner_q == 2'b01) begin
          m0_ack   = 1'b1;
          m0_err   = err_q;
          m0_rdata = rdata_q;
        end else if (owner_q == 2'b10) begin
          m1_ack   = 1'b1;
          m1_err   = err_q;
          m1_rdata = rdata_q;
        end
      end
      default: ;
    endcase
  end

  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign owner     = owner_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: each task drives one scenario and checks hand-computed values.
// Latency is counted in rising edges from the cycle req is first driven to the cycle ack is seen.
module tb_data_bus_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        bus_wd, bus_rd;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ready, bus_busy;
  logic [1:0]  owner, dbg_state;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, wd_cnt = 0, both_cnt = 0, dual_ack = 0, ack_cnt = 0;
  logic [31:0] st_addr, st_wdata;
  logic [1:0]  st_size;

  data_bus_arbiter #(.TIMEOUT(16), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .bus_wd(bus_wd), .bus_rd(bus_rd), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .bus_busy(bus_busy), .owner(owner), .dbg_state(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // bus-side monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus_rd) rd_cnt++;
    if (bus_wd) wd_cnt++;
    if (bus_rd && bus_wd) both_cnt++;
    if (m0_ack && m1_ack) dual_ack++;
    if (m0_ack || m1_ack) ack_cnt++;
    if (bus_rd || bus_wd) begin
      st_addr  = bus_addr;
      st_wdata = bus_wdata;
      st_size  = bus_size;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts;
    rd_cnt = 0; wd_cnt = 0; ack_cnt = 0;
  endtask

  task automatic drive_req(input int who, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (who == 0) begin
      m0_req = 1'b1; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // driver: waits (bounded) for the given requester's ack, returning what it saw
  task automatic wait_ack(input int who, input int limit, output int cyc, output logic seen,
                          output logic err, output logic [31:0] rdata, output logic other);
    cyc = 0; seen = 1'b0; err = 1'b0; rdata = '0; other = 1'b0;
    while (!seen && cyc < limit) begin
      tick();
      cyc++;
      if (who == 0 ? m0_ack : m1_ack) begin
        seen  = 1'b1;
        err   = (who == 0) ? m0_err : m1_err;
        rdata = (who == 0) ? m0_rdata : m1_rdata;
        other = (who == 0) ? m1_ack : m0_ack;
      end
    end
    if (who == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_size = 2'b10; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b1; m1_size = 2'b10; m1_addr = '0; m1_wdata = '0;
    bus_ready = 1'b1; bus_busy = 1'b0; bus_rdata = '0;
    tick(); tick();
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner: got %b expected 00", owner); end
    checks++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0000", {m0_ack, m1_ack, m0_err, m1_err}); end
    checks++; if ({bus_rd, bus_wd} !== 2'b00) begin errors++; $display("FAIL reset_strobe: got %b expected 00", {bus_rd, bus_wd}); end
    m0_req = 1'b0; m1_req = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read;
    int cyc; logic seen, err, other; logic [31:0] rdata;
    clear_counts();
    bus_rdata = 32'hDEADBEEF;
    drive_req(0, 1'b0, 2'b10, 32'h10, 32'h0);
    wait_ack(0, 20, cyc, seen, err, rdata, other);
    checks++; if (seen !== 1'b1 || cyc != 4) begin errors++; $display("FAIL read_latency: got %0d cycles (seen=%b) expected 4", cyc, seen); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h expected deadbeef", rdata); end
    checks++; if (err !== 1'b0 || other !== 1'b0) begin errors++; $display("FAIL read_err: got err=%b m1_ack=%b expected 0 0", err, other); end
    checks++; if (rd_cnt != 1 || wd_cnt != 0) begin errors++; $display("FAIL read_strobes: got rd=%0d wd=%0d expected 1 0", rd_cnt, wd_cnt); end
    checks++; if (st_addr !== 32'h10 || st_size !== 2'b10) begin errors++; $display("FAIL read_bus_addr: got %h/%b expected 00000010/10", st_addr, st_size); end
    tick();
    checks++; if (owner !== 2'b00 || dbg_state !== 2'd0) begin errors++; $display("FAIL read_idle: got owner=%b state=%0d expected 00 0", owner, dbg_state); end
  endtask

  task automatic test_write;
    int cyc; logic seen, err, other; logic [31:0] rdata;
    clear_counts();
    bus_rdata = 32'hFFFFFFFF;
    drive_req(1, 1'b1, 2'b10, 32'h20, 32'h12345678);
    wait_ack(1, 20, cyc, seen, err, rdata, other);
    checks++; if (seen !== 1'b1 || cyc != 3) begin errors++; $display("FAIL write_latency: got %0d cycles (seen=%b) expected 3", cyc, seen); end
    checks++; if (err !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL write_resp: got err=%b rdata=%h expected 0 00000000", err, rdata); end
    checks++; if (wd_cnt != 1 || rd_cnt != 0) begin errors++; $display("FAIL write_strobes: got wd=%0d rd=%0d expected 1 0", wd_cnt, rd_cnt); end
    checks++; if (st_wdata !== 32'h12345678 || st_addr !== 32'h20) begin errors++; $display("FAIL write_bus_data: got %h@%h expected 12345678@00000020", st_wdata, st_addr); end
    tick();
  endtask

  task automatic test_misaligned;
    int          who_t [5] = '{1, 0, 0, 0, 1};
    logic        we_t  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  sz_t  [5] = '{2'b10, 2'b01, 2'b11, 2'b01, 2'b00};
    logic [31:0] ad_t  [5] = '{32'h12, 32'h33, 32'h0, 32'h2, 32'h3};
    logic        xe_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int          xc_t  [5] = '{1, 1, 1, 4, 4};
    int cyc; logic seen, err, other; logic [31:0] rdata;
    bus_rdata = 32'hA5A5A5A5;
    for (int i = 0; i < 5; i++) begin
      clear_counts();
      drive_req(who_t[i], we_t[i], sz_t[i], ad_t[i], 32'h0);
      wait_ack(who_t[i], 20, cyc, seen, err, rdata, other);
      checks++; if (seen !== 1'b1 || cyc != xc_t[i] || err !== xe_t[i]) begin errors++; $display("FAIL align_%0d: got cyc=%0d err=%b expected cyc=%0d err=%b", i, cyc, err, xc_t[i], xe_t[i]); end
      checks++; if (rd_cnt + wd_cnt != (xe_t[i] ? 0 : 1)) begin errors++; $display("FAIL align_strobe_%0d: got %0d strobes expected %0d", i, rd_cnt + wd_cnt, xe_t[i] ? 0 : 1); end
      checks++; if (rdata !== (xe_t[i] ? 32'h0 : 32'hA5A5A5A5)) begin errors++; $display("FAIL align_rdata_%0d: got %h", i, rdata); end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] own_q[$];
    logic [1:0] exp_own [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    int         exp_who [3] = '{0, 1, 0};
    logic [1:0] prev;
    int acks, cyc;
    prev = 2'b00; acks = 0; cyc = 0; dual_ack = 0;
    drive_req(0, 1'b1, 2'b10, 32'h100, 32'h1);
    drive_req(1, 1'b1, 2'b10, 32'h200, 32'h2);
    while (acks < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (owner !== prev) begin own_q.push_back(owner); prev = owner; end
      if (m0_ack || m1_ack) begin
        checks++; if ((m1_ack ? 1 : 0) != exp_who[acks]) begin errors++; $display("FAIL rr_grant_%0d: got m%0d expected m%0d", acks, m1_ack ? 1 : 0, exp_who[acks]); end
        acks++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    checks++; if (acks != 3) begin errors++; $display("FAIL rr_acks: got %0d expected 3", acks); end
    checks++; if (own_q.size() != 5) begin errors++; $display("FAIL rr_owner_len: got %0d expected 5", own_q.size()); end
    for (int i = 0; i < 5 && i < own_q.size(); i++) begin
      checks++; if (own_q[i] !== exp_own[i]) begin errors++; $display("FAIL rr_owner_%0d: got %b expected %b", i, own_q[i], exp_own[i]); end
    end
    checks++; if (dual_ack != 0 || both_cnt != 0) begin errors++; $display("FAIL rr_exclusive: got dual_ack=%0d both_strobe=%0d expected 0 0", dual_ack, both_cnt); end
    tick();
  endtask

  task automatic test_timeout;
    int cyc, cmd_cyc; logic seen, err; logic [31:0] rdata;
    clear_counts();
    bus_ready = 1'b0;
    drive_req(0, 1'b0, 2'b10, 32'h40, 32'h0);
    cyc = 0; cmd_cyc = 0; seen = 1'b0; err = 1'b0; rdata = '0;
    while (!seen && cyc < 30) begin
      tick();
      cyc++;
      if (dbg_state == 2'd1) cmd_cyc++;
      if (m0_ack) begin seen = 1'b1; err = m0_err; rdata = m0_rdata; end
    end
    m0_req = 1'b0;
    checks++; if (seen !== 1'b1 || cyc != 17 || cmd_cyc != 16) begin errors++; $display("FAIL timeout_latency: got cyc=%0d cmd=%0d expected 17 16", cyc, cmd_cyc); end
    checks++; if (err !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL timeout_err: got err=%b rdata=%h expected 1 00000000", err, rdata); end
    checks++; if (rd_cnt + wd_cnt != 0) begin errors++; $display("FAIL timeout_strobe: got %0d expected 0", rd_cnt + wd_cnt); end
    tick(); tick(); tick();
    bus_ready = 1'b1;
  endtask

  task automatic test_busy_stall;
    int cyc; logic seen, err;
    clear_counts();
    bus_busy = 1'b1;
    drive_req(1, 1'b1, 2'b00, 32'h7, 32'h55);
    cyc = 0; seen = 1'b0; err = 1'b0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (m1_ack) begin seen = 1'b1; err = m1_err; end
      bus_busy = (cyc < 4);
    end
    m1_req = 1'b0; bus_busy = 1'b0;
    checks++; if (seen !== 1'b1 || cyc != 6 || err !== 1'b0) begin errors++; $display("FAIL busy_latency: got cyc=%0d err=%b expected 6 0", cyc, err); end
    checks++; if (wd_cnt != 1 || st_size !== 2'b00 || st_addr !== 32'h7) begin errors++; $display("FAIL busy_strobe: got wd=%0d size=%b addr=%h expected 1 00 00000007", wd_cnt, st_size, st_addr); end
    tick();
  endtask

  task automatic test_reset_mid_wait;
    int cyc; logic seen, err, other; logic [31:0] rdata;
    clear_counts();
    bus_rdata = 32'hCAFEF00D;
    drive_req(0, 1'b0, 2'b10, 32'h44, 32'h0);
    tick(); tick();
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rstwait_pre: got state %0d expected 2", dbg_state); end
    rst = 1'b0; m0_req = 1'b0;
    tick();
    checks++; if (dbg_state !== 2'd0 || owner !== 2'b00 || m0_ack !== 1'b0) begin errors++; $display("FAIL rstwait_abort: got state=%0d owner=%b ack=%b expected 0 00 0", dbg_state, owner, m0_ack); end
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if (ack_cnt != 0) begin errors++; $display("FAIL rstwait_noack: got %0d acks expected 0", ack_cnt); end
    bus_rdata = 32'h0BADF00D;
    drive_req(1, 1'b0, 2'b10, 32'h8, 32'h0);
    tick();
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL rstwait_regrant: got owner %b expected 10", owner); end
    wait_ack(1, 20, cyc, seen, err, rdata, other);
    checks++; if (seen !== 1'b1 || cyc != 3 || rdata !== 32'h0BADF00D || err !== 1'b0) begin errors++; $display("FAIL rstwait_read: got cyc=%0d rdata=%h err=%b expected 3 0badf00d 0", cyc, rdata, err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_busy_stall();
    test_reset_mid_wait();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles with both strobes expected 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
